// File: rtl/rv32_mod_muldiv_if.sv
// rv32_mod_muldiv_if
//   Request/response bundle between the execute stage (master) and the
//   iterative RV32M multiply/divide unit (slave).
//   start/kill/func/read0_data/read1_data : core -> unit
//   busy/done/result                      : unit -> core
interface rv32_mod_muldiv_if;
   logic        start;
   logic        kill;
   logic [2:0]  func;
   logic [31:0] read0_data;
   logic [31:0] read1_data;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, kill, func, read0_data, read1_data,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, func, read0_data, read1_data,
      output busy, done, result
   );
endinterface

// File: rtl/rv32_mod_muldiv.sv
// rv32_mod_muldiv
//   Iterative RV32M multiply/divide unit. Every funct3 op takes a fixed
//   34 cycles from the start edge to the done pulse: 32 radix-2 steps on
//   unsigned magnitudes, one sign-fix cycle, one done cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : start/kill/func/operands in, busy/done/result out
module rv32_mod_muldiv (
   input  logic               clk,
   input  logic               rst_n,
   rv32_mod_muldiv_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   typedef struct packed {
      logic [2:0] func;
      logic       neg_a;   // rs1 treated as signed and negative
      logic       neg_b;   // rs2 treated as signed and negative
      logic       b_zero;  // divisor was zero
   } op_t;

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [5:0]  cnt_q;
   logic [31:0] hi_q;      // mul: product high / div: partial remainder
   logic [31:0] lo_q;      // mul: multiplier->product low / div: dividend->quotient
   logic [31:0] opb_q;     // mul: multiplicand / div: divisor (magnitudes)
   logic [31:0] result_q;

   logic        accept;
   logic        sgn_a, sgn_b;
   logic [31:0] mag_a, mag_b;

   // ---------------------------------------------------------------
   // Operand decode at start
   // ---------------------------------------------------------------
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (bus.func)
         3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
         3'b010:                 sgn_a = 1'b1;
         default: ;
      endcase
      op_d.func   = bus.func;
      op_d.neg_a  = sgn_a & bus.read0_data[31];
      op_d.neg_b  = sgn_b & bus.read1_data[31];
      op_d.b_zero = (bus.read1_data == 32'd0);
      mag_a = op_d.neg_a ? -bus.read0_data : bus.read0_data;
      mag_b = op_d.neg_b ? -bus.read1_data : bus.read1_data;
   end

   // A new op may be taken in IDLE and in the DONE cycle; kill always wins.
   assign accept = bus.start & ~bus.kill & ((state_q == IDLE) | (state_q == DONE));

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            if (bus.kill)               state_d = IDLE;
            else if (cnt_q == 6'd31)    state_d = FIX;
         end
         FIX:  state_d = bus.kill ? IDLE : DONE;
         DONE: state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy   = (state_q == RUN) | (state_q == FIX);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;

   // ---------------------------------------------------------------
   // One radix-2 step
   // ---------------------------------------------------------------
   logic [32:0] mul_sum, div_shift, div_trial;
   logic [31:0] step_hi, step_lo;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
      div_shift = {hi_q, lo_q[31]};
      div_trial = div_shift - {1'b0, opb_q};
      if (op_q.func[2]) begin
         // Restoring divide. An accepted trial is always below the divisor,
         // and a rejected shift is too, so the remainder fits 32 bits.
         if (!div_trial[32]) begin
            step_hi = div_trial[31:0];
            step_lo = {lo_q[30:0], 1'b1};
         end else begin
            step_hi = div_shift[31:0];
            step_lo = {lo_q[30:0], 1'b0};
         end
      end else begin
         // Shift-add: the product grows in from the top as the multiplier
         // shifts out of the bottom of lo_q.
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], lo_q[31:1]};
      end
   end

   // ---------------------------------------------------------------
   // Sign fix and result select
   // ---------------------------------------------------------------
   logic [63:0] prod_s;
   logic [31:0] quot_s, rem_s, fix_res;

   always_comb begin
      prod_s = (op_q.neg_a ^ op_q.neg_b) ? -{hi_q, lo_q} : {hi_q, lo_q};
      // Divide by zero leaves quotient all-ones and remainder |rs1|;
      // skipping the quotient negation keeps 0xFFFFFFFF for both flavours.
      quot_s = ((op_q.neg_a ^ op_q.neg_b) & ~op_q.b_zero) ? -lo_q : lo_q;
      rem_s  = op_q.neg_a ? -hi_q : hi_q;
      case (op_q.func)
         3'b000:                 fix_res = prod_s[31:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_s[63:32];
         3'b100, 3'b101:         fix_res = quot_s;
         default:                fix_res = rem_s;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q  <= op_d;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= op_d.func[2] ? mag_a : mag_b;
            opb_q <= op_d.func[2] ? mag_b : mag_a;
         end else if ((state_q == RUN) && !bus.kill) begin
            cnt_q <= cnt_q + 6'd1;
            hi_q  <= step_hi;
            lo_q  <= step_lo;
         end
         // A kill in FIX leaves the previous result visible.
         if ((state_q == FIX) && !bus.kill)
            result_q <= fix_res;
      end
   end

endmodule
